// File: rtl/sdc_arb_pkg.sv
// Shared types and constants for the multi-port SDRAM host arbiter:
// FSM encoding, burst length decode and reset values.
package sdc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } arb_state_t;

  localparam logic       RST_SDR_REQ  = 1'b0;
  localparam logic       RST_REQ_WR_N = 1'b1;
  localparam logic [1:0] RST_REQ_LEN  = 2'd0;
  localparam logic [3:0] RST_BEAT_CNT = 4'd0;

  // Length code 0/1/2/3 selects a 1/2/4/8 beat burst.
  function automatic logic [3:0] len_to_beats(input logic [1:0] len);
    return 4'd1 << len;
  endfunction

endpackage

// File: rtl/sdc_rr_arb.sv
// Combinational one-hot round-robin picker: the first requester at or
// after ptr (wrapping past NPORTS-1 to 0) wins.
module sdc_rr_arb
  import sdc_arb_pkg::*;
#(
  parameter  int NPORTS = 4,
  localparam int IDX_W  = $clog2(NPORTS)
) (
  input  logic [NPORTS-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NPORTS-1:0] gnt,
  output logic [IDX_W-1:0]  idx,
  output logic              any
);

  logic [IDX_W-1:0] pos;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int k = 0; k < NPORTS; k++) begin
      pos = IDX_W'((int'(ptr) + k) % NPORTS);
      if (!any && req[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/sdc_mport_arb.sv
// Multi-port host front-end for the SDRAM controller: round-robin arbitration
// of NPORTS request channels onto one controller host interface.
// Build option: define SDC_ARB_PRIO_EN to make port 0 a high-priority port.
module sdc_mport_arb
  import sdc_arb_pkg::*;
#(
  parameter  int NPORTS = 4,
  parameter  int ADDR_W = 22,
  parameter  int DATA_W = 32,
  parameter  int MASK_W = 4,
  localparam int IDX_W  = $clog2(NPORTS)
) (
  input  logic                     mclk,
  input  logic                     s_reset,
  input  logic [NPORTS-1:0]        p_req,
  input  logic [NPORTS*ADDR_W-1:0] p_adr,
  input  logic [NPORTS*2-1:0]      p_len,
  input  logic [NPORTS-1:0]        p_wr_n,
  input  logic [NPORTS*DATA_W-1:0] p_wr_data,
  input  logic [NPORTS*MASK_W-1:0] p_wr_en_n,
  output logic [NPORTS-1:0]        p_ack,
  output logic [NPORTS-1:0]        p_wr_next,
  output logic [NPORTS-1:0]        p_rd_valid,
  output logic [DATA_W-1:0]        p_rd_data,
  output logic                     sdr_req,
  output logic [ADDR_W-1:0]        sdr_req_adr,
  output logic [1:0]               sdr_req_len,
  output logic                     sdr_req_wr_n,
  output logic [DATA_W-1:0]        sdr_wr_data,
  output logic [MASK_W-1:0]        sdr_wr_en_n,
  input  logic                     sdr_req_ack,
  input  logic                     sdr_wr_next,
  input  logic                     sdr_rd_valid,
  input  logic [DATA_W-1:0]        sdr_rd_data,
  input  logic                     sdr_init_done,
  output logic [IDX_W-1:0]         gnt_idx,
  output logic                     busy
);

  arb_state_t        state, state_d;
  logic [IDX_W-1:0]  rr_ptr, rr_ptr_d, gnt_idx_d, rr_next;
  logic              sdr_req_d, sdr_req_wr_n_d;
  logic [ADDR_W-1:0] sdr_req_adr_d;
  logic [1:0]        sdr_req_len_d;
  logic [3:0]        beat_cnt, beat_cnt_d;
  logic              gnt_prio, gnt_prio_d;

  logic [NPORTS-1:0] arb_req, arb_gnt, win_oh, gnt_oh;
  logic [IDX_W-1:0]  arb_idx, win_idx;
  logic              arb_any, win_any, win_prio;
  logic [ADDR_W-1:0] win_adr;
  logic [1:0]        win_len;
  logic              win_wr_n;
  logic              beat_act, last_beat;

  sdc_rr_arb #(.NPORTS(NPORTS)) u_rr (
    .req (arb_req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

`ifdef SDC_ARB_PRIO_EN
  // Port 0 bypasses the rotation; the others share it.
  assign arb_req  = p_req & {{(NPORTS-1){1'b1}}, 1'b0};
  assign win_prio = p_req[0];
  assign win_any  = p_req[0] | arb_any;
  assign win_idx  = p_req[0] ? '0 : arb_idx;
  assign win_oh   = p_req[0] ? NPORTS'(1) : arb_gnt;
`else
  assign arb_req  = p_req;
  assign win_prio = 1'b0;
  assign win_any  = arb_any;
  assign win_idx  = arb_idx;
  assign win_oh   = arb_gnt;
`endif

  always_comb begin
    win_adr  = '0;
    win_len  = '0;
    win_wr_n = 1'b1;
    for (int i = 0; i < NPORTS; i++) begin
      if (win_oh[i]) begin
        win_adr  = p_adr[i*ADDR_W +: ADDR_W];
        win_len  = p_len[i*2 +: 2];
        win_wr_n = p_wr_n[i];
      end
    end
  end

  assign busy = (state != IDLE);

  // Controller strobes reach only the granted port, and never while idle or in reset.
  always_comb begin
    gnt_oh = '0;
    if (busy && !s_reset) gnt_oh[gnt_idx] = 1'b1;
  end

  assign p_ack      = (state == REQ && sdr_req_ack) ? gnt_oh : '0;
  assign p_wr_next  = gnt_oh & {NPORTS{sdr_wr_next}};
  assign p_rd_valid = gnt_oh & {NPORTS{sdr_rd_valid}};
  assign p_rd_data  = sdr_rd_data;

  assign sdr_wr_data = busy ? p_wr_data[int'(gnt_idx)*DATA_W +: DATA_W] : '0;
  assign sdr_wr_en_n = busy ? p_wr_en_n[int'(gnt_idx)*MASK_W +: MASK_W] : '1;

  assign beat_act  = busy && (sdr_req_wr_n ? sdr_rd_valid : sdr_wr_next);
  assign last_beat = (beat_cnt == 4'd0) || (beat_act && beat_cnt == 4'd1);
  assign rr_next   = (gnt_idx == IDX_W'(NPORTS-1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    state_d        = state;
    sdr_req_d      = sdr_req;
    sdr_req_adr_d  = sdr_req_adr;
    sdr_req_len_d  = sdr_req_len;
    sdr_req_wr_n_d = sdr_req_wr_n;
    gnt_idx_d      = gnt_idx;
    gnt_prio_d     = gnt_prio;
    rr_ptr_d       = rr_ptr;
    beat_cnt_d     = beat_cnt;
    if (beat_act && beat_cnt != 4'd0) beat_cnt_d = beat_cnt - 4'd1;
    case (state)
      IDLE: begin
        if (sdr_init_done && win_any) begin
          sdr_req_d      = 1'b1;
          sdr_req_adr_d  = win_adr;
          sdr_req_len_d  = win_len;
          sdr_req_wr_n_d = win_wr_n;
          gnt_idx_d      = win_idx;
          gnt_prio_d     = win_prio;
          beat_cnt_d     = len_to_beats(win_len);
          state_d        = REQ;
        end
      end
      REQ: begin
        if (sdr_req_ack) begin
          sdr_req_d = 1'b0;
          if (last_beat) begin
            state_d = IDLE;
            if (!gnt_prio) rr_ptr_d = rr_next;
          end else begin
            state_d = XFER;
          end
        end
      end
      XFER: begin
        if (last_beat) begin
          state_d = IDLE;
          if (!gnt_prio) rr_ptr_d = rr_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (s_reset) begin
      state        <= IDLE;
      sdr_req      <= RST_SDR_REQ;
      sdr_req_adr  <= '0;
      sdr_req_len  <= RST_REQ_LEN;
      sdr_req_wr_n <= RST_REQ_WR_N;
      gnt_idx      <= '0;
      gnt_prio     <= 1'b0;
      rr_ptr       <= '0;
      beat_cnt     <= RST_BEAT_CNT;
    end else begin
      state        <= state_d;
      sdr_req      <= sdr_req_d;
      sdr_req_adr  <= sdr_req_adr_d;
      sdr_req_len  <= sdr_req_len_d;
      sdr_req_wr_n <= sdr_req_wr_n_d;
      gnt_idx      <= gnt_idx_d;
      gnt_prio     <= gnt_prio_d;
      rr_ptr       <= rr_ptr_d;
      beat_cnt     <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_sdc_mport_arb.sv
// Directed self-checking bench for sdc_mport_arb (4 ports, default widths).
module tb_sdc_mport_arb;

  localparam int NP = 4;
  localparam int AW = 22;
  localparam int DW = 32;
  localparam int MW = 4;

  logic             mclk = 1'b0;
  logic             s_reset;
  logic [NP-1:0]    p_req;
  logic [NP*AW-1:0] p_adr;
  logic [NP*2-1:0]  p_len;
  logic [NP-1:0]    p_wr_n;
  logic [NP*DW-1:0] p_wr_data;
  logic [NP*MW-1:0] p_wr_en_n;
  logic [NP-1:0]    p_ack, p_wr_next, p_rd_valid;
  logic [DW-1:0]    p_rd_data;
  logic             sdr_req, sdr_req_wr_n;
  logic [AW-1:0]    sdr_req_adr;
  logic [1:0]       sdr_req_len;
  logic [DW-1:0]    sdr_wr_data;
  logic [MW-1:0]    sdr_wr_en_n;
  logic             sdr_req_ack, sdr_wr_next, sdr_rd_valid, sdr_init_done;
  logic [DW-1:0]    sdr_rd_data;
  logic [1:0]       gnt_idx;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 mclk = ~mclk;

  sdc_mport_arb #(.NPORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) dut (
    .mclk(mclk), .s_reset(s_reset),
    .p_req(p_req), .p_adr(p_adr), .p_len(p_len), .p_wr_n(p_wr_n),
    .p_wr_data(p_wr_data), .p_wr_en_n(p_wr_en_n),
    .p_ack(p_ack), .p_wr_next(p_wr_next), .p_rd_valid(p_rd_valid), .p_rd_data(p_rd_data),
    .sdr_req(sdr_req), .sdr_req_adr(sdr_req_adr), .sdr_req_len(sdr_req_len),
    .sdr_req_wr_n(sdr_req_wr_n), .sdr_wr_data(sdr_wr_data), .sdr_wr_en_n(sdr_wr_en_n),
    .sdr_req_ack(sdr_req_ack), .sdr_wr_next(sdr_wr_next), .sdr_rd_valid(sdr_rd_valid),
    .sdr_rd_data(sdr_rd_data), .sdr_init_done(sdr_init_done),
    .gnt_idx(gnt_idx), .busy(busy)
  );

  task automatic cyc();
    @(posedge mclk);
    #1;
  endtask

  task automatic ctl_idle();
    sdr_req_ack  = 1'b0;
    sdr_wr_next  = 1'b0;
    sdr_rd_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    ctl_idle();
    p_req   = '0;
    s_reset = 1'b1;
    cyc();
    s_reset = 1'b0;
  endtask

  task automatic set_port(input int i, input logic [AW-1:0] adr, input logic [1:0] len,
                          input logic wr_n, input logic [DW-1:0] d, input logic [MW-1:0] en_n);
    p_adr[i*AW +: AW]     = adr;
    p_len[i*2 +: 2]       = len;
    p_wr_n[i]             = wr_n;
    p_wr_data[i*DW +: DW] = d;
    p_wr_en_n[i*MW +: MW] = en_n;
  endtask

  task automatic test_reset();
    s_reset = 1'b1;
    ctl_idle();
    cyc();
    cyc();
    sdr_wr_next  = 1'b1;
    sdr_rd_valid = 1'b1;
    #1;
    n_tests++;
    if ({sdr_req, sdr_req_adr, sdr_req_len, sdr_req_wr_n} !== {1'b0, 22'h0, 2'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_req: got req=%0b adr=%0h len=%0d wr_n=%0b, want 0/0/0/1",
               sdr_req, sdr_req_adr, sdr_req_len, sdr_req_wr_n);
    end
    n_tests++;
    if ({busy, gnt_idx} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_busy_gnt: got busy=%0b gnt=%0d, want 0/0", busy, gnt_idx);
    end
    n_tests++;
    if ({p_ack, p_wr_next, p_rd_valid} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_strobes: got %0h, want 0", {p_ack, p_wr_next, p_rd_valid});
    end
    n_tests++;
    if ({sdr_wr_data, sdr_wr_en_n} !== {32'h0, 4'hF}) begin
      n_fail++;
      $display("FAIL reset_wdata: got data=%0h en_n=%0h, want 0/f", sdr_wr_data, sdr_wr_en_n);
    end
    ctl_idle();
    s_reset = 1'b0;
    cyc();
  endtask

  task automatic test_single_write();
    int pulses;
    pulse_reset();
    sdr_init_done = 1'b1;
    set_port(2, 22'h1234, 2'd2, 1'b0, 32'hDEADBEEF, 4'h0);
    p_req = 4'b0100;
    cyc();
    n_tests++;
    if ({sdr_req, sdr_req_adr, sdr_req_len, sdr_req_wr_n, gnt_idx} !== {1'b1, 22'h1234, 2'd2, 1'b0, 2'd2}) begin
      n_fail++;
      $display("FAIL single_req: got req=%0b adr=%0h len=%0d wr_n=%0b gnt=%0d, want 1/1234/2/0/2",
               sdr_req, sdr_req_adr, sdr_req_len, sdr_req_wr_n, gnt_idx);
    end
    n_tests++;
    if (p_ack !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_ack_early: got %b, want 0000", p_ack);
    end
    cyc();
    sdr_req_ack = 1'b1;
    #1;
    n_tests++;
    if (p_ack !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_ack: got %b, want 0100", p_ack);
    end
    cyc();
    sdr_req_ack = 1'b0;
    p_req = '0;
    #1;
    n_tests++;
    if ({sdr_req, busy, p_ack} !== {1'b0, 1'b1, 4'b0000}) begin
      n_fail++;
      $display("FAIL single_xfer: got req=%0b busy=%0b ack=%b, want 0/1/0000", sdr_req, busy, p_ack);
    end
    n_tests++;
    if ({sdr_wr_data, sdr_wr_en_n} !== {32'hDEADBEEF, 4'h0}) begin
      n_fail++;
      $display("FAIL single_wdata: got %0h/%0h, want deadbeef/0", sdr_wr_data, sdr_wr_en_n);
    end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      sdr_wr_next = 1'b1;
      #1;
      if (p_wr_next === 4'b0100) pulses++;
      cyc();
      sdr_wr_next = 1'b0;
    end
    n_tests++;
    if ({pulses, busy} !== {32'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL single_beats: got pulses=%0d busy=%0b, want 4/0", pulses, busy);
    end
    n_tests++;
    if ({sdr_wr_data, sdr_wr_en_n} !== {32'h0, 4'hF}) begin
      n_fail++;
      $display("FAIL single_idle_wdata: got %0h/%0h, want 0/f", sdr_wr_data, sdr_wr_en_n);
    end
  endtask

  task automatic test_round_robin();
    int exp_g [5];
    exp_g = '{0, 1, 2, 3, 0};
    pulse_reset();
    sdr_init_done = 1'b1;
    for (int i = 0; i < NP; i++) set_port(i, AW'(22'h100 + i), 2'd0, 1'b1, 32'h0, 4'hF);
    p_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cyc();
      n_tests++;
      if ({sdr_req, gnt_idx} !== {1'b1, 2'(exp_g[k])}) begin
        n_fail++;
        $display("FAIL rr_gnt[%0d]: got req=%0b gnt=%0d, want 1/%0d", k, sdr_req, gnt_idx, exp_g[k]);
      end
      sdr_req_ack = 1'b1;
      #1;
      n_tests++;
      if (p_ack !== 4'(1 << exp_g[k])) begin
        n_fail++;
        $display("FAIL rr_ack[%0d]: got %b, want %b", k, p_ack, 4'(1 << exp_g[k]));
      end
      cyc();
      sdr_req_ack  = 1'b0;
      sdr_rd_valid = 1'b1;
      sdr_rd_data  = 32'hA5A50000 + k;
      #1;
      n_tests++;
      if ({p_rd_valid, p_rd_data} !== {4'(1 << exp_g[k]), 32'hA5A50000 + k}) begin
        n_fail++;
        $display("FAIL rr_rdv[%0d]: got %b/%0h, want %b/%0h", k, p_rd_valid, p_rd_data,
                 4'(1 << exp_g[k]), 32'hA5A50000 + k);
      end
      cyc();
      sdr_rd_valid = 1'b0;
      #1;
      n_tests++;
      if ({busy, p_rd_valid} !== 5'b0) begin
        n_fail++;
        $display("FAIL rr_done[%0d]: got busy=%0b rdv=%b, want 0/0000", k, busy, p_rd_valid);
      end
    end
    p_req = '0;
  endtask

  task automatic test_ack_last();
    pulse_reset();
    sdr_init_done = 1'b1;
    set_port(1, 22'h2222, 2'd0, 1'b0, 32'h11112222, 4'h3);
    p_req = 4'b0010;
    cyc();
    n_tests++;
    if ({sdr_req, gnt_idx} !== {1'b1, 2'd1}) begin
      n_fail++;
      $display("FAIL ackl_gnt: got req=%0b gnt=%0d, want 1/1", sdr_req, gnt_idx);
    end
    sdr_req_ack = 1'b1;
    sdr_wr_next = 1'b1;
    #1;
    n_tests++;
    if ({p_ack, p_wr_next} !== {4'b0010, 4'b0010}) begin
      n_fail++;
      $display("FAIL ackl_strobes: got ack=%b wn=%b, want 0010/0010", p_ack, p_wr_next);
    end
    cyc();
    ctl_idle();
    #1;
    n_tests++;
    if ({busy, sdr_req} !== 2'b00) begin
      n_fail++;
      $display("FAIL ackl_idle: got busy=%0b req=%0b, want 0/0", busy, sdr_req);
    end
    cyc();
    n_tests++;
    if ({sdr_req, gnt_idx} !== {1'b1, 2'd1}) begin
      n_fail++;
      $display("FAIL ackl_turnaround: got req=%0b gnt=%0d, want 1/1", sdr_req, gnt_idx);
    end
    sdr_req_ack = 1'b1;
    sdr_wr_next = 1'b1;
    cyc();
    ctl_idle();
    p_req = '0;
    cyc();
  endtask

  task automatic test_init_gate();
    pulse_reset();
    sdr_init_done = 1'b0;
    for (int i = 0; i < NP; i++) set_port(i, AW'(22'h300 + i), 2'd0, 1'b1, 32'h0, 4'hF);
    p_req = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      sdr_rd_valid = 1'b1;
      sdr_wr_next  = 1'b1;
      #1;
      n_tests++;
      if ({sdr_req, busy, p_rd_valid, p_wr_next} !== 10'b0) begin
        n_fail++;
        $display("FAIL init_hold[%0d]: got req=%0b busy=%0b rdv=%b wn=%b, want all 0",
                 k, sdr_req, busy, p_rd_valid, p_wr_next);
      end
      cyc();
    end
    ctl_idle();
    sdr_init_done = 1'b1;
    cyc();
    n_tests++;
    if ({sdr_req, gnt_idx, sdr_req_adr} !== {1'b1, 2'd0, 22'h300}) begin
      n_fail++;
      $display("FAIL init_first: got req=%0b gnt=%0d adr=%0h, want 1/0/300", sdr_req, gnt_idx, sdr_req_adr);
    end
    sdr_req_ack  = 1'b1;
    sdr_rd_valid = 1'b1;
    p_req = '0;
    cyc();
    ctl_idle();
    cyc();
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    sdr_init_done = 1'b1;
    set_port(3, 22'h3ABCD, 2'd3, 1'b1, 32'h0, 4'hF);
    p_req = 4'b1000;
    cyc();
    sdr_req_ack = 1'b1;
    cyc();
    sdr_req_ack = 1'b0;
    p_req = '0;
    for (int i = 0; i < 3; i++) begin
      sdr_rd_valid = 1'b1;
      cyc();
    end
    n_tests++;
    if ({busy, gnt_idx} !== {1'b1, 2'd3}) begin
      n_fail++;
      $display("FAIL rmid_inflight: got busy=%0b gnt=%0d, want 1/3", busy, gnt_idx);
    end
    s_reset = 1'b1;
    #1;
    n_tests++;
    if (p_rd_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL rmid_during: got rdv=%b, want 0000", p_rd_valid);
    end
    cyc();
    s_reset = 1'b0;
    n_tests++;
    if ({busy, gnt_idx, sdr_req, sdr_req_adr, sdr_req_len, sdr_req_wr_n} !== {1'b0, 2'd0, 1'b0, 22'h0, 2'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL rmid_values: got busy=%0b gnt=%0d req=%0b adr=%0h len=%0d wr_n=%0b, want 0/0/0/0/0/1",
               busy, gnt_idx, sdr_req, sdr_req_adr, sdr_req_len, sdr_req_wr_n);
    end
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++;
      if ({p_rd_valid, busy} !== 5'b0) begin
        n_fail++;
        $display("FAIL rmid_after[%0d]: got rdv=%b busy=%0b, want 0000/0", k, p_rd_valid, busy);
      end
      cyc();
    end
    ctl_idle();
  endtask

  task automatic test_priority();
    int exp_g;
    pulse_reset();
    sdr_init_done = 1'b1;
    set_port(0, 22'h400, 2'd0, 1'b1, 32'h0, 4'hF);
    set_port(3, 22'h403, 2'd0, 1'b1, 32'h0, 4'hF);
    p_req = 4'b1001;
    for (int k = 0; k < 4; k++) begin
`ifdef SDC_ARB_PRIO_EN
      exp_g = 0;
`else
      exp_g = (k % 2 == 0) ? 0 : 3;
`endif
      cyc();
      n_tests++;
      if ({sdr_req, gnt_idx} !== {1'b1, 2'(exp_g)}) begin
        n_fail++;
        $display("FAIL prio_gnt[%0d]: got req=%0b gnt=%0d, want 1/%0d", k, sdr_req, gnt_idx, exp_g);
      end
      sdr_req_ack  = 1'b1;
      sdr_rd_valid = 1'b1;
      cyc();
      ctl_idle();
    end
    p_req = '0;
    cyc();
  endtask

  initial begin
    s_reset       = 1'b1;
    sdr_init_done = 1'b0;
    sdr_rd_data   = '0;
    p_req         = '0;
    p_adr         = '0;
    p_len         = '0;
    p_wr_n        = '1;
    p_wr_data     = '0;
    p_wr_en_n     = '1;
    ctl_idle();
    test_reset();
    test_single_write();
    test_round_robin();
    test_ack_last();
    test_init_gate();
    test_reset_mid();
    test_priority();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
